// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer.
// Owns the PC, runs a request/ready handshake with a variable-latency
// instruction memory and loads the IF/ID register. A 1-entry skid buffer
// catches a returning word while decode is stalled. An EX/MEM redirect
// has highest priority. All outputs are registered.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'd0,
   parameter logic [31:0] PC_STEP  = 32'd1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        EX_MEM_PCSrc,
   input  logic [31:0] EX_MEM_NPC,
   input  logic        ID_stall,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic [31:0] IF_ID_instr,
   output logic [31:0] IF_ID_npc,
   output logic        IF_ID_valid,
   output logic [31:0] PC
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,   // request outstanding, response is wanted
      HOLD    = 2'd2,   // word parked in skid buffer, no request out
      DISCARD = 2'd3    // request outstanding, response will be dropped
   } state_t;

   // One fetched word plus its fall-through address.
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] npc;
   } ifid_t;

   state_t      state;
   ifid_t       skid;
   logic        skid_valid;
   logic [31:0] pc_inc;
   logic [31:0] addr_inc;

   // Wrapping 32-bit increments; no carry out is kept.
   always_comb begin
      pc_inc   = PC + PC_STEP;
      addr_inc = mem_addr + PC_STEP;
   end

   // Fetch FSM: PC, memory request, skid buffer and IF/ID register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         PC          <= RESET_PC;
         mem_req     <= 1'b0;
         mem_addr    <= RESET_PC;
         IF_ID_instr <= 32'h0;
         IF_ID_npc   <= 32'h0;
         IF_ID_valid <= 1'b0;
         skid        <= '0;
         skid_valid  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // Nothing is in flight, so a redirect simply replaces PC
               // as the first address to fetch.
               mem_req <= 1'b1;
               state   <= FETCH;
               if (EX_MEM_PCSrc) begin
                  PC          <= EX_MEM_NPC;
                  mem_addr    <= EX_MEM_NPC;
                  IF_ID_valid <= 1'b0;
                  IF_ID_instr <= 32'h0;
                  skid_valid  <= 1'b0;
               end else begin
                  mem_addr <= PC;
               end
            end

            FETCH: begin
               if (EX_MEM_PCSrc) begin
                  PC          <= EX_MEM_NPC;
                  IF_ID_valid <= 1'b0;
                  IF_ID_instr <= 32'h0;
                  skid_valid  <= 1'b0;
                  if (mem_ready) begin
                     // Returning word is wrong-path; go straight to target.
                     mem_addr <= EX_MEM_NPC;
                  end else begin
                     // Handshake must finish first; keep req/addr stable.
                     state <= DISCARD;
                  end
               end else if (!mem_ready) begin
                  if (!ID_stall) begin
                     IF_ID_valid <= 1'b0;
                     IF_ID_instr <= 32'h0;
                  end
               end else if (!ID_stall) begin
                  IF_ID_instr <= mem_rdata;
                  IF_ID_npc   <= addr_inc;
                  IF_ID_valid <= 1'b1;
                  PC          <= pc_inc;
                  mem_addr    <= pc_inc;
               end else begin
                  // Decode is frozen: park the word, stop requesting.
                  skid.instr <= mem_rdata;
                  skid.npc   <= addr_inc;
                  skid_valid <= 1'b1;
                  PC         <= pc_inc;
                  mem_req    <= 1'b0;
                  state      <= HOLD;
               end
            end

            HOLD: begin
               if (EX_MEM_PCSrc) begin
                  PC          <= EX_MEM_NPC;
                  IF_ID_valid <= 1'b0;
                  IF_ID_instr <= 32'h0;
                  skid_valid  <= 1'b0;
                  mem_req     <= 1'b1;
                  mem_addr    <= EX_MEM_NPC;
                  state       <= FETCH;
               end else if (!ID_stall) begin
                  // Release: parked word enters IF/ID and the next fetch
                  // is issued on the same edge.
                  IF_ID_instr <= skid.instr;
                  IF_ID_npc   <= skid.npc;
                  IF_ID_valid <= skid_valid;
                  skid_valid  <= 1'b0;
                  mem_req     <= 1'b1;
                  mem_addr    <= PC;
                  state       <= FETCH;
               end
            end

            DISCARD: begin
               // IF/ID was flushed on entry and stays a bubble here.
               if (EX_MEM_PCSrc) begin
                  PC          <= EX_MEM_NPC;
                  IF_ID_valid <= 1'b0;
                  IF_ID_instr <= 32'h0;
                  skid_valid  <= 1'b0;
               end
               if (mem_ready) begin
                  // Last redirect wins, including one arriving this cycle.
                  mem_addr <= EX_MEM_PCSrc ? EX_MEM_NPC : PC;
                  state    <= FETCH;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed pins plus randomized stall/redirect/latency
// traffic against a transaction-level reference model.
module tb_fetch_ctrl;

   localparam logic [31:0] RESET_PC = 32'd0;
   localparam logic [31:0] PC_STEP  = 32'd1;

   logic        clk = 1'b0;
   logic        rst;
   logic        EX_MEM_PCSrc;
   logic [31:0] EX_MEM_NPC;
   logic        ID_stall;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic [31:0] IF_ID_instr;
   logic [31:0] IF_ID_npc;
   logic        IF_ID_valid;
   logic [31:0] PC;

   always #5 clk = ~clk;

   fetch_ctrl #(.RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) dut (
      .clk(clk), .rst(rst),
      .EX_MEM_PCSrc(EX_MEM_PCSrc), .EX_MEM_NPC(EX_MEM_NPC),
      .ID_stall(ID_stall),
      .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .IF_ID_instr(IF_ID_instr), .IF_ID_npc(IF_ID_npc),
      .IF_ID_valid(IF_ID_valid), .PC(PC)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Tracks the outstanding request, whether its response is dead,
   // the list of words waiting for decode, and the IF/ID contents.
   bit          m_ok = 1'b0;
   logic        m_req;
   logic [31:0] m_addr, m_pc;
   bit          m_dead;
   logic [63:0] m_held[$];
   logic        m_v;
   logic [31:0] m_instr, m_npc;
   logic [31:0] w_instr, w_npc;

   always @(posedge clk) begin
      if (rst) begin
         m_ok = 1'b1; m_req = 1'b0; m_addr = RESET_PC; m_pc = RESET_PC;
         m_dead = 1'b0; m_held.delete();
         m_v = 1'b0; m_instr = 32'h0; m_npc = 32'h0;
      end else if (m_ok) begin
         if (EX_MEM_PCSrc) begin
            m_pc = EX_MEM_NPC; m_v = 1'b0; m_instr = 32'h0; m_held.delete();
            if (m_req && !mem_ready) m_dead = 1'b1;
            else begin m_req = 1'b1; m_addr = EX_MEM_NPC; m_dead = 1'b0; end
         end else if (!m_req) begin
            if (m_held.size() == 0) begin
               m_req = 1'b1; m_addr = m_pc;
            end else if (!ID_stall) begin
               {m_instr, m_npc} = m_held.pop_front();
               m_v = 1'b1; m_req = 1'b1; m_addr = m_pc;
            end
         end else if (!mem_ready) begin
            if (!ID_stall) begin m_v = 1'b0; m_instr = 32'h0; end
         end else if (m_dead) begin
            m_dead = 1'b0; m_addr = m_pc;
         end else begin
            w_instr = mem_rdata;
            w_npc   = m_addr + PC_STEP;
            m_pc    = m_pc + PC_STEP;
            if (!ID_stall) begin
               m_v = 1'b1; m_instr = w_instr; m_npc = w_npc; m_addr = m_pc;
            end else begin
               m_held.push_back({w_instr, w_npc}); m_req = 1'b0;
            end
         end
      end
   end

   // Cycle-by-cycle compare against the model.
   always @(negedge clk) begin
      if (m_ok) begin
         chk("mem_req", {31'h0, mem_req}, {31'h0, m_req});
         chk("mem_addr", mem_addr, m_addr);
         chk("PC", PC, m_pc);
         chk("IF_ID_valid", {31'h0, IF_ID_valid}, {31'h0, m_v});
         chk("IF_ID_instr", IF_ID_instr, m_instr);
         if (m_v) chk("IF_ID_npc", IF_ID_npc, m_npc);
      end
   end

   // ---------------- memory responder ----------------
   // Word at address a is a + 0x100. Latency chosen per request.
   int lat_mode = 1;   // 0 = random 1..4 per request
   int age      = 0;
   int cur_lat  = 1;

   task automatic drive_mem();
      if (mem_req !== 1'b1) begin
         mem_ready = 1'b0; age = 0; mem_rdata = $urandom;
      end else begin
         if (age == 0) cur_lat = (lat_mode == 0) ? int'($urandom_range(1, 4)) : lat_mode;
         mem_ready = (age >= cur_lat - 1);
         mem_rdata = mem_ready ? mem_addr + 32'h100 : $urandom;
         age       = mem_ready ? 0 : age + 1;
      end
   endtask

   // Advance one cycle; returns just after the falling edge with memory
   // inputs for the new cycle already driven.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      #1;
      drive_mem();
   endtask

   int nv;

   initial begin
      rst = 1'b1; EX_MEM_PCSrc = 1'b0; EX_MEM_NPC = 32'h0; ID_stall = 1'b0;
      mem_ready = 1'b0; mem_rdata = 32'h0;
      repeat (3) tick();
      chk("rst_req", {31'h0, mem_req}, 32'h0);
      chk("rst_addr", mem_addr, 32'h0);
      chk("rst_pc", PC, 32'h0);
      chk("rst_valid", {31'h0, IF_ID_valid}, 32'h0);
      chk("rst_instr", IF_ID_instr, 32'h0);
      rst = 1'b0;                                          // cycle 0
      tick();                                              // cycle 1
      chk("c1_req", {31'h0, mem_req}, 32'h1);
      chk("c1_addr", mem_addr, 32'h0);
      tick();                                              // cycle 2
      chk("c2_valid", {31'h0, IF_ID_valid}, 32'h1);
      chk("c2_instr", IF_ID_instr, 32'h100);
      chk("c2_npc", IF_ID_npc, 32'h1);
      tick();
      chk("c3_instr", IF_ID_instr, 32'h101);
      chk("c3_npc", IF_ID_npc, 32'h2);
      tick();
      chk("c4_instr", IF_ID_instr, 32'h102);
      chk("c4_pc", PC, 32'h3);

      // latency 3
      lat_mode = 3;
      tick();                                              // c5
      chk("l3_addr_a", mem_addr, 32'h4);
      tick();
      chk("l3_addr_b", mem_addr, 32'h4);
      chk("l3_bubble_v", {31'h0, IF_ID_valid}, 32'h0);
      chk("l3_bubble_i", IF_ID_instr, 32'h0);
      tick();
      chk("l3_addr_c", mem_addr, 32'h4);
      nv = 0;
      repeat (9) begin tick(); nv += int'(IF_ID_valid); end   // c8..c16
      chk("l3_rate", nv, 32'd3);

      // redirect to 5, then to 0x40 while the request to 5 is pending
      EX_MEM_PCSrc = 1'b1; EX_MEM_NPC = 32'h5;
      tick();                                              // c17
      chk("rd5_addr", mem_addr, 32'h5);
      chk("rd5_valid", {31'h0, IF_ID_valid}, 32'h0);
      EX_MEM_NPC = 32'h40;
      tick();
      EX_MEM_PCSrc = 1'b0;
      chk("disc_addr_a", mem_addr, 32'h5);
      tick();
      chk("disc_addr_b", mem_addr, 32'h5);
      tick();                                              // c20
      chk("rd40_addr", mem_addr, 32'h40);
      chk("rd40_valid", {31'h0, IF_ID_valid}, 32'h0);
      repeat (3) tick();                                   // c23
      chk("rd40_instr", IF_ID_instr, 32'h140);
      chk("rd40_npc", IF_ID_npc, 32'h41);
      chk("rd40_v", {31'h0, IF_ID_valid}, 32'h1);
      lat_mode = 1;
      repeat (4) tick();                                   // c27

      // stall into HOLD, redirect while holding
      ID_stall = 1'b1;
      tick();
      chk("hold_req", {31'h0, mem_req}, 32'h0);
      EX_MEM_PCSrc = 1'b1; EX_MEM_NPC = 32'h200;
      tick();
      chk("hrd_req", {31'h0, mem_req}, 32'h1);
      chk("hrd_addr", mem_addr, 32'h200);
      chk("hrd_valid", {31'h0, IF_ID_valid}, 32'h0);
      EX_MEM_PCSrc = 1'b0; ID_stall = 1'b0;
      tick();                                              // c30
      chk("hrd_instr", IF_ID_instr, 32'h300);
      chk("hrd_npc", IF_ID_npc, 32'h201);

      // stall for three cycles while a word returns
      ID_stall = 1'b1;
      repeat (3) begin
         tick();
         chk("st_instr", IF_ID_instr, 32'h300);
         chk("st_req", {31'h0, mem_req}, 32'h0);
      end
      ID_stall = 1'b0;
      tick();
      chk("rel_instr", IF_ID_instr, 32'h301);
      chk("rel_npc", IF_ID_npc, 32'h202);
      chk("rel_addr", mem_addr, 32'h202);
      tick();
      chk("rel2_instr", IF_ID_instr, 32'h302);

      // redirect together with stall
      EX_MEM_PCSrc = 1'b1; EX_MEM_NPC = 32'h80; ID_stall = 1'b1;
      tick();
      chk("rs_valid", {31'h0, IF_ID_valid}, 32'h0);
      chk("rs_addr", mem_addr, 32'h80);
      EX_MEM_PCSrc = 1'b0; ID_stall = 1'b0;
      tick();
      chk("rs_instr", IF_ID_instr, 32'h180);
      chk("rs_npc", IF_ID_npc, 32'h81);

      // wrap at 0xFFFFFFFF
      EX_MEM_PCSrc = 1'b1; EX_MEM_NPC = 32'hFFFF_FFFF;
      tick();
      EX_MEM_PCSrc = 1'b0;
      chk("wr_addr", mem_addr, 32'hFFFF_FFFF);
      tick();
      chk("wr_instr", IF_ID_instr, 32'h0000_00FF);
      chk("wr_npc", IF_ID_npc, 32'h0);
      chk("wr_pc", PC, 32'h0);
      chk("wr_addr0", mem_addr, 32'h0);

      // reset during an outstanding request
      lat_mode = 3;
      tick();
      rst = 1'b1;
      tick();
      chk("mr_req", {31'h0, mem_req}, 32'h0);
      chk("mr_pc", PC, RESET_PC);
      chk("mr_addr", mem_addr, RESET_PC);
      chk("mr_valid", {31'h0, IF_ID_valid}, 32'h0);
      chk("mr_instr", IF_ID_instr, 32'h0);
      rst = 1'b0;

      // randomized traffic
      lat_mode = 0;
      repeat (1500) begin
         tick();
         ID_stall     = ($urandom_range(0, 3) == 0);
         EX_MEM_PCSrc = ($urandom_range(0, 19) == 0);
         EX_MEM_NPC   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 2)
                                                    : $urandom_range(0, 1023);
         rst          = ($urandom_range(0, 299) == 0);
      end
      rst = 1'b0; EX_MEM_PCSrc = 1'b0; ID_stall = 1'b0;
      repeat (4) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
